// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 compression sequencer and its datapath.
// Holds the controller state encoding, the round count, the schedule threshold
// and the initial hash value words.
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ROUND = 3'd3,
    ST_ADD   = 3'd4,
    ST_DONE  = 3'd5
  } sha256_state_e;

  localparam int SHA256_ROUNDS = 64;

  // Rounds below this index take W directly from the input block.
  localparam int SHA256_SCHED_DIRECT = 16;

  // Initial hash value H0..H7, consumed by the datapath on ld_iv.
  localparam logic [31:0] SHA256_IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational 64 x 32 SHA-256 round constant table K[t].
module sha256_k_rom (
  input  logic [5:0]  idx,
  output logic [31:0] k
);

  localparam logic [31:0] K_TABLE [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Pure table lookup; idx always lies within 0..63.
  always_comb begin
    k = K_TABLE[idx];
  end

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 compression sequencer: accepts one block job, optionally loads the
// IV, loads A..H, steps the rounds and adds the result back into H0..H7.
// Optional feature macro: SHA256_ROUND_CTRL_STEP_EN adds a 'step' input that
// gates round advancement.
//
// Handshake: a job transfers on a rising clk edge where start_valid and
// start_ready are both high; start_ready is high only in IDLE, and
// start_valid outside IDLE is ignored (no queueing).
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = SHA256_ROUNDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_valid,
  input  logic          first_block,
`ifdef SHA256_ROUND_CTRL_STEP_EN
  input  logic          step,
`endif
  output logic          start_ready,
  output logic          ld_iv,
  output logic          ld_work,
  output logic          en_round,
  output logic          w_sel,
  output logic [5:0]    round_idx,
  output logic [31:0]   k_const,
  output logic          en_hash_add,
  output logic          busy,
  output logic          done,
  output sha256_state_e dbg_state
);

  localparam logic [5:0] LAST_IDX  = 6'(ROUNDS - 1);
  localparam logic [5:0] SCHED_IDX = 6'(SHA256_SCHED_DIRECT);

  sha256_state_e state_q, state_d;
  logic [5:0]    cnt_q, cnt_d;
  logic          fb_q, fb_d;
  logic          adv;

`ifdef SHA256_ROUND_CTRL_STEP_EN
  assign adv = step;
`else
  assign adv = 1'b1;
`endif

  // State, round counter and latched first_block flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fb_q    <= fb_d;
    end
  end

  // Next-state and counter sequencing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fb_d    = fb_q;
    case (state_q)
      ST_IDLE: begin
        if (start_valid) begin
          fb_d    = first_block;
          state_d = first_block ? ST_INIT : ST_LOAD;
        end
      end
      ST_INIT: state_d = ST_LOAD;
      ST_LOAD: begin
        cnt_d   = 6'd0;
        state_d = ST_ROUND;
      end
      ST_ROUND: begin
        if (adv) begin
          if (cnt_q == LAST_IDX) begin
            cnt_d   = 6'd0;
            state_d = ST_ADD;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_ADD:  state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath enables decoded from registered state; only en_round may see step.
  always_comb begin
    start_ready = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    ld_iv       = (state_q == ST_INIT) && fb_q;
    ld_work     = (state_q == ST_LOAD);
    en_round    = (state_q == ST_ROUND) && adv;
    en_hash_add = (state_q == ST_ADD);
    done        = (state_q == ST_DONE);
    round_idx   = 6'd0;
    w_sel       = 1'b0;
    if (state_q == ST_ROUND) begin
      round_idx = cnt_q;
      w_sel     = (cnt_q >= SCHED_IDX);
    end
    dbg_state = state_q;
  end

  sha256_k_rom u_k_rom (
    .idx (round_idx),
    .k   (k_const)
  );

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Self-checking bench for sha256_round_ctrl. A job-level model expands each
// accepted job into its sequence of phases; a monitor compares every cycle's
// outputs against the phase at the head of the expected queue.
module tb_sha256_round_ctrl;
  import sha256_pkg::*;

  localparam logic [7:0] C_INIT = 8'h80;
  localparam logic [7:0] C_LOAD = 8'h81;
  localparam logic [7:0] C_ADD  = 8'h82;
  localparam logic [7:0] C_DONE = 8'h83;

  localparam logic [31:0] K_REF [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start_valid;
  logic          first_block;
  logic          step_tb;
  logic          start_ready, ld_iv, ld_work, en_round, w_sel;
  logic [5:0]    round_idx;
  logic [31:0]   k_const;
  logic          en_hash_add, busy, done;
  sha256_state_e dbg_state;

  sha256_round_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start_valid (start_valid),
    .first_block (first_block),
`ifdef SHA256_ROUND_CTRL_STEP_EN
    .step        (step_tb),
`endif
    .start_ready (start_ready),
    .ld_iv       (ld_iv),
    .ld_work     (ld_work),
    .en_round    (en_round),
    .w_sel       (w_sel),
    .round_idx   (round_idx),
    .k_const     (k_const),
    .en_hash_add (en_hash_add),
    .busy        (busy),
    .done        (done),
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [7:0] exp_q[$];
  bit         model_idle = 1'b1;
  int         acc_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;

  // Output vector: {start_ready,busy,done,ld_iv,ld_work,en_round,en_hash_add,w_sel,round_idx,k_const}
  function automatic logic [45:0] exp_vec(input logic [7:0] code, input logic stp, input bit idle);
    logic [45:0] v;
    if (idle) begin
      v = {8'b1000_0000, 6'd0, K_REF[0]};
    end else if (code == C_INIT) begin
      v = {8'b0101_0000, 6'd0, K_REF[0]};
    end else if (code == C_LOAD) begin
      v = {8'b0100_1000, 6'd0, K_REF[0]};
    end else if (code == C_ADD) begin
      v = {8'b0100_0010, 6'd0, K_REF[0]};
    end else if (code == C_DONE) begin
      v = {8'b0110_0000, 6'd0, K_REF[0]};
    end else begin
      v = {3'b010, 2'b00, stp, 1'b0, (code[5:0] >= 6'd16), code[5:0], K_REF[code[5:0]]};
    end
    return v;
  endfunction

  // Model + monitor: accept jobs at the rising edge, compare at the falling edge.
  always begin
    logic [45:0] act, expv;
    logic [7:0]  code;
    @(posedge clk);
    if (reset && model_idle && start_valid) begin
      if (first_block) exp_q.push_back(C_INIT);
      exp_q.push_back(C_LOAD);
      for (int t = 0; t < SHA256_ROUNDS; t++) exp_q.push_back(8'(t));
      exp_q.push_back(C_ADD);
      exp_q.push_back(C_DONE);
      acc_cnt++;
      model_idle = 1'b0;
    end
    @(negedge clk);
    act = {start_ready, busy, done, ld_iv, ld_work, en_round, en_hash_add, w_sel, round_idx, k_const};
    code = 8'h00;
    if (!reset) begin
      exp_q.delete();
      model_idle = 1'b1;
      expv = exp_vec(8'h00, 1'b0, 1'b1);
    end else if (exp_q.size() == 0) begin
      model_idle = 1'b1;
      expv = exp_vec(8'h00, 1'b0, 1'b1);
    end else begin
      model_idle = 1'b0;
      code = exp_q[0];
      expv = exp_vec(code, step_tb, 1'b0);
      if (code >= C_INIT || step_tb) void'(exp_q.pop_front());
    end
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL cycle_outputs t=%0t phase=%h rst=%b actual=%h required=%h",
               $time, code, reset, act, expv);
    end
  end

  // Round-advance enable: always 1 unless the step feature is compiled in.
`ifdef SHA256_ROUND_CTRL_STEP_EN
  always begin
    @(posedge clk);
    #1 step_tb = ($urandom_range(0, 3) != 0);
  end
`else
  initial step_tb = 1'b1;
`endif

  // ---------------- driver tasks ----------------
  task automatic run_job(input bit fb, input bit hold);
    int n0;
    bit ok;
    n0 = acc_cnt;
    ok = 1'b0;
    start_valid = 1'b1;
    first_block = fb;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (acc_cnt != n0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL accept_timeout actual=no_acceptance required=acceptance");
    end
    if (!hold) start_valid = 1'b0;
    first_block = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (model_idle && exp_q.size() == 0) ok = 1'b1;
    end
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL idle_timeout actual=busy required=idle");
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset       = 1'b0;
    start_valid = 1'b0;
    first_block = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    run_job(1'b1, 1'b0);
    wait_idle();
    run_job(1'b0, 1'b0);
    wait_idle();

    for (int j = 0; j < 4; j++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      run_job(1'($urandom_range(0, 1)), 1'b0);
      wait_idle();
    end

    // start_valid held high across three jobs
    run_job(1'b1, 1'b1);
    run_job(1'b0, 1'b1);
    run_job(1'b1, 1'b1);
    start_valid = 1'b0;
    wait_idle();

    // reset asserted in the middle of ROUND (around round 30)
    run_job(1'b1, 1'b0);
    repeat (32) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    run_job(1'b1, 1'b0);
    wait_idle();
    repeat (3) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
